rs_encoder: RTL and testbench
=============================

RS_ENCODER -- requirements
Module: rs_encoder

Interface
REQ-001 SHALL use clk, input, 1 bit, rising-edge clock for all state.
REQ-002 SHALL use rstn, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL accept rsfec_ena, input, 1 bit, FEC enable (sampled only under RS_ENC_BYPASS_EN).
REQ-004 SHALL accept tx_data_vld, input, 1 bit, message word valid.
REQ-005 SHALL accept tx_data, input, 64 bits, message word; byte 0 = [63:56], sent first.
REQ-006 SHALL drive tx_data_rdy, output, 1 bit; a word is accepted when tx_data_vld and tx_data_rdy are both high.
REQ-007 SHALL drive enc_data_vld, output, 1 bit, encoded word valid; downstream has no backpressure.
REQ-008 SHALL drive enc_data, output, 64 bits, encoded stream word; byte 0 = [63:56].
REQ-009 SHALL drive enc_sof, output, 1 bit; high with enc_data_vld on word 0 of each superframe.

Function
REQ-010 SHALL implement RS(194,190) over GF(2^8), field poly 0x11D, g(x)=x^4+0x0F x^3+0x36 x^2+0x78 x+0x40 (roots alpha^0..alpha^3).
REQ-011 SHALL encode systematically: 190 message bytes, then 4 parity bytes, highest-degree coefficient first.
REQ-012 SHALL frame a superframe as 4 codewords: 95 input words (760 bytes) in, 97 output words (776 bytes) out, packed with no gaps; codeword k starts at output byte 194k.
REQ-013 SHALL handle input words that straddle codeword boundaries: in the same cycle, update parity with the tail bytes of codeword k and seed codeword k+1 with the head bytes.
REQ-014 SHALL insert parity in the same output word as the last message bytes when they fit; any remaining bytes carry into the next word.
REQ-015 SHALL update the parity LFSR 8 bytes per accepted cycle; the LFSR clears at each codeword start.
REQ-016 SHALL register outputs with 1-cycle latency: each output word is valid the cycle after its last contributing input byte is accepted.
REQ-017 SHALL deassert tx_data_rdy for exactly one cycle when 8 residual bytes are buffered (after codeword 1 and codeword 3 complete); that cycle emits the buffered word.
REQ-018 SHALL keep tx_data_rdy high in all other cycles, including while tx_data_vld is low.
REQ-019 SHALL treat input bubbles (tx_data_vld low) as pauses only: no LFSR or counter change, and enc_data_vld low the next cycle unless a residual word is pending.
REQ-020 SHALL track superframe position with a word counter (0..94) and a codeword-phase counter (0..3); both wrap to 0 after input word 94.
REQ-021 SHALL emit exactly 97 enc_data_vld pulses per 95 accepted words.
REQ-022 SHALL hold enc_data at its last value while enc_data_vld is low.

Reset
REQ-023 SHALL reset enc_data_vld=0, enc_data=0, enc_sof=0, tx_data_rdy=1, and clear all counters, the LFSR and the residual buffer.
REQ-024 SHALL, on reset asserted mid-superframe, discard the partial superframe; the first word accepted after release is message byte 0 of codeword 0.

Configuration
REQ-025 With RS_ENC_BYPASS_EN defined and rsfec_ena=0, SHALL pass tx_data to enc_data with 1-cycle latency, hold tx_data_rdy=1, add no parity, hold enc_sof=0 and hold counters in reset.
REQ-026 With RS_ENC_BYPASS_EN defined, SHALL apply an rsfec_ena change only at a superframe boundary (both counters at 0, no residual).
REQ-027 Without RS_ENC_BYPASS_EN, SHALL ignore rsfec_ena and always encode.

Structure
REQ-028 SHALL place these in shared package rs_pkg: field poly, generator coefficients, CW_LEN=194, MSG_LEN=190, PAR_LEN=4, SF_IN_WORDS=95, SF_OUT_WORDS=97, and a GF-multiply-by-constant function.
REQ-029 SHALL use one sub-module, rs_enc_lfsr: combinational 8-byte parallel parity update with a byte-count/mask input, instantiated twice (tail and head).

Verification
REQ-030 All-zero superframe (95 words of 0) -> 97 words of 0; enc_sof on word 0; tx_data_rdy low exactly 2 cycles.
REQ-031 Codeword 0 all zero except message byte 189 = 0x01 -> output bytes 190..193 = 0x0F,0x36,0x78,0x40.
REQ-032 Random superframes through the team's rs_decoder -> data matches input with no errors flagged; each codeword's 4 syndromes = 0.
REQ-033 Random tx_data_vld bubbles (50%) -> output byte stream identical to the gap-free run.
REQ-034 rstn pulsed at input word 40 -> partial frame dropped; next superframe's output matches the golden model, with enc_sof on its first word.
REQ-035 RS_ENC_BYPASS_EN defined, rsfec_ena=0, input 0x0123456789ABCDEF -> identical enc_data one cycle later, tx_data_rdy always 1.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared constants and GF(2^8) helpers for the RS(194,190) superframe encoder.
package rs_pkg;

   localparam logic [8:0] FIELD_POLY = 9'h11D;
   localparam logic [7:0] GEN_C3     = 8'h0F;
   localparam logic [7:0] GEN_C2     = 8'h36;
   localparam logic [7:0] GEN_C1     = 8'h78;
   localparam logic [7:0] GEN_C0     = 8'h40;

   localparam int CW_LEN       = 194;
   localparam int MSG_LEN      = 190;
   localparam int PAR_LEN      = 4;
   localparam int SF_IN_WORDS  = 95;
   localparam int SF_OUT_WORDS = 97;
   localparam int WORD_BYTES   = 8;
   localparam int CW_PER_SF    = (SF_OUT_WORDS * WORD_BYTES) / CW_LEN;

   // Shift-and-add multiply; with a constant c this collapses to an XOR network.
   function automatic logic [7:0] gf_mul_const(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) acc = acc ^ sh;
         sh = {sh[6:0], 1'b0} ^ (sh[7] ? FIELD_POLY[7:0] : 8'h00);
      end
      return acc;
   endfunction

   function automatic int cw_end_byte(input logic [1:0] ph);
      return MSG_LEN * (int'(ph) + 1);
   endfunction

   // Input word that holds the last message byte of codeword ph.
   function automatic logic [6:0] bnd_word(input logic [1:0] ph);
      return 7'((cw_end_byte(ph) - 1) / WORD_BYTES);
   endfunction

   // Number of codeword-ph bytes at the front of its boundary word.
   function automatic logic [3:0] tail_len(input logic [1:0] ph);
      return 4'(cw_end_byte(ph) - WORD_BYTES * int'(bnd_word(ph)));
   endfunction

endpackage

// File: rtl/rs_enc_lfsr.sv
// Combinational 8-byte parallel parity update; bytes whose mask bit is 0 are skipped.
module rs_enc_lfsr
   import rs_pkg::*;
(
   input  logic [31:0] state_in,
   input  logic [63:0] data,
   input  logic [7:0]  byte_mask,
   output logic [31:0] state_out
);

   logic [7:0] r3, r2, r1, r0, fb;

   // Byte i is data[63-8i -: 8]; state_in[31:24] is the highest-degree parity byte.
   always_comb begin
      r3 = state_in[31:24];
      r2 = state_in[23:16];
      r1 = state_in[15:8];
      r0 = state_in[7:0];
      fb = '0;
      for (int i = 0; i < 8; i++) begin
         fb = data[63-8*i -: 8] ^ r3;
         if (byte_mask[i]) begin
            r3 = r2 ^ gf_mul_const(fb, GEN_C3);
            r2 = r1 ^ gf_mul_const(fb, GEN_C2);
            r1 = r0 ^ gf_mul_const(fb, GEN_C1);
            r0 = gf_mul_const(fb, GEN_C0);
         end
      end
      state_out = {r3, r2, r1, r0};
   end

endmodule

// File: rtl/rs_encoder.sv
// RS(194,190) superframe encoder: 95 words in, 97 words out, parity packed without gaps.
// Optional bypass mode controlled by rsfec_ena is compiled in with RS_ENC_BYPASS_EN.
module rs_encoder
   import rs_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        rsfec_ena,
   input  logic        tx_data_vld,
   input  logic [63:0] tx_data,
   output logic        tx_data_rdy,
   output logic        enc_data_vld,
   output logic [63:0] enc_data,
   output logic        enc_sof
);

   logic [6:0]                     wcnt;
   logic [$clog2(CW_PER_SF)-1:0]   phase;
   logic [31:0]                    par_st;
   logic [63:0]                    res_buf;
   logic [3:0]                     res_cnt;

   logic        accept, at_sf_start, enc_mode, is_bnd, last_word;
   logic [3:0]  tail_n;
   logic [7:0]  tail_mask, head_mask;
   logic [31:0] par_tail, par_head;
   logic [95:0] new_vec;
   logic [3:0]  new_cnt;
   logic [127:0] cat_vec;
   logic [4:0]  sum_cnt;
   logic [3:0]  res_cnt_nxt;

   assign accept      = tx_data_vld & tx_data_rdy;
   assign at_sf_start = (wcnt == '0) && (phase == '0) && (res_cnt == '0);

`ifdef RS_ENC_BYPASS_EN
   // Mid-superframe the encoder always runs, so rsfec_ena only takes effect at a boundary.
   assign enc_mode = rsfec_ena | ~at_sf_start;
`else
   logic unused_rsfec_ena;
   assign unused_rsfec_ena = rsfec_ena;
   assign enc_mode         = 1'b1;
`endif

   assign is_bnd    = (wcnt == bnd_word(phase));
   assign tail_n    = tail_len(phase);
   assign last_word = (wcnt == 7'(SF_IN_WORDS - 1));

   always_comb begin
      tail_mask = '0;
      head_mask = '0;
      for (int i = 0; i < 8; i++) begin
         tail_mask[i] = ~is_bnd | (4'(i) < tail_n);
         head_mask[i] = is_bnd & (4'(i) >= tail_n);
      end
   end

   rs_enc_lfsr u_lfsr_tail (
      .state_in  (par_st),
      .data      (tx_data),
      .byte_mask (tail_mask),
      .state_out (par_tail)
   );

   rs_enc_lfsr u_lfsr_head (
      .state_in  (32'h0),
      .data      (tx_data),
      .byte_mask (head_mask),
      .state_out (par_head)
   );

   // Boundary word expands to tail bytes, 4 parity bytes, then head bytes of the next codeword.
   always_comb begin
      new_vec = {tx_data, 32'h0};
      new_cnt = 4'(WORD_BYTES);
      if (is_bnd) begin
         new_cnt = 4'(WORD_BYTES + PAR_LEN);
         for (int j = 0; j < WORD_BYTES + PAR_LEN; j++) begin
            if (j < int'(tail_n))
               new_vec[95-8*j -: 8] = tx_data[63-8*j -: 8];
            else if (j < int'(tail_n) + PAR_LEN)
               new_vec[95-8*j -: 8] = par_tail[31-8*(j-int'(tail_n)) -: 8];
            else
               new_vec[95-8*j -: 8] = tx_data[63-8*(j-PAR_LEN) -: 8];
         end
      end
   end

   assign sum_cnt     = 5'(res_cnt) + 5'(new_cnt);
   assign res_cnt_nxt = 4'(sum_cnt - 5'(WORD_BYTES));
   assign cat_vec     = {res_buf, 64'h0} | ({new_vec, 32'h0} >> {res_cnt, 3'b000});

   // Output register stage: one word per cycle, residual bytes carried left-aligned in res_buf.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wcnt         <= '0;
         phase        <= '0;
         par_st       <= '0;
         res_buf      <= '0;
         res_cnt      <= '0;
         tx_data_rdy  <= 1'b1;
         enc_data_vld <= 1'b0;
         enc_data     <= '0;
         enc_sof      <= 1'b0;
      end else if (res_cnt == 4'(WORD_BYTES)) begin
         enc_data     <= res_buf;
         enc_data_vld <= 1'b1;
         enc_sof      <= 1'b0;
         res_buf      <= '0;
         res_cnt      <= '0;
         tx_data_rdy  <= 1'b1;
      end else if (accept && enc_mode) begin
         enc_data     <= cat_vec[127:64];
         enc_data_vld <= 1'b1;
         enc_sof      <= at_sf_start;
         res_buf      <= cat_vec[63:0];
         res_cnt      <= res_cnt_nxt;
         tx_data_rdy  <= (res_cnt_nxt != 4'(WORD_BYTES));
         par_st       <= is_bnd ? par_head : par_tail;
         if (last_word) begin
            wcnt  <= '0;
            phase <= '0;
         end else begin
            wcnt  <= wcnt + 7'd1;
            phase <= phase + {1'b0, is_bnd};
         end
      end else if (accept) begin
         enc_data     <= tx_data;
         enc_data_vld <= 1'b1;
         enc_sof      <= 1'b0;
      end else begin
         enc_data_vld <= 1'b0;
         enc_sof      <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rs_encoder.sv
// Self-checking bench for rs_encoder against a polynomial-division reference model.
module tb_rs_encoder;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        rsfec_ena = 1'b1;
   logic        tx_data_vld = 1'b0;
   logic [63:0] tx_data = '0;
   logic        tx_data_rdy;
   logic        enc_data_vld;
   logic [63:0] enc_data;
   logic        enc_sof;

   rs_encoder dut (
      .clk          (clk),
      .rstn         (rstn),
      .rsfec_ena    (rsfec_ena),
      .tx_data_vld  (tx_data_vld),
      .tx_data      (tx_data),
      .tx_data_rdy  (tx_data_rdy),
      .enc_data_vld (enc_data_vld),
      .enc_data     (enc_data),
      .enc_sof      (enc_sof)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        sof;
      logic [63:0] d;
   } out_t;

   typedef struct {
      logic [7:0]  v;
      logic [31:0] par;
   } vec_t;

   out_t       out_q[$];
   int         rdy_low = 0;
   int         total = 0;
   int         bad = 0;
   logic [7:0] msg_b [760];
   logic [7:0] exp_b [776];
   logic [7:0] ob    [776];
   logic [7:0] gen   [0:4] = '{8'h01, 8'h0F, 8'h36, 8'h78, 8'h40};

   always @(negedge clk) begin
      if (enc_data_vld) out_q.push_back({enc_sof, enc_data});
      if (!tx_data_rdy) rdy_low++;
   end

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int p, x;
      p = 0;
      x = int'(a);
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x << 1;
         if (x >= 256) x = x ^ 'h11D;
      end
      return 8'(p);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Remainder of m(x)*x^4 divided by g(x), long division, per codeword.
   task automatic build_expected();
      logic [7:0] work [194];
      logic [7:0] c;
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 194; i++) work[i] = (i < 190) ? msg_b[190*k+i] : 8'h00;
         for (int i = 0; i < 190; i++) begin
            c = work[i];
            for (int j = 1; j <= 4; j++) work[i+j] = work[i+j] ^ gmul(c, gen[j]);
         end
         for (int i = 0; i < 190; i++) exp_b[194*k+i] = msg_b[190*k+i];
         for (int j = 0; j < 4; j++) exp_b[194*k+190+j] = work[190+j];
      end
   endtask

   task automatic send_words(input int nwords, input int pct);
      logic [63:0] w_d;
      int tries;
      for (int w = 0; w < nwords; w++) begin
         w_d = '0;
         for (int b = 0; b < 8; b++) w_d = {w_d[55:0], msg_b[8*w+b]};
         while (pct > 0 && $urandom_range(99) < pct) begin
            tx_data_vld = 1'b0;
            @(posedge clk); #1;
         end
         tx_data_vld = 1'b1;
         tx_data     = w_d;
         tries       = 0;
         while (!tx_data_rdy && tries < 8) begin
            @(posedge clk); #1;
            tries++;
         end
         if (tries >= 8) chk("rdy_timeout", 64'(tx_data_rdy), 64'd1);
         @(posedge clk); #1;
      end
      tx_data_vld = 1'b0;
   endtask

   task automatic run_sf(input string name, input int pct, input bit synd);
      int base, r0;
      logic [63:0] e;
      logic [7:0]  s;
      base = out_q.size();
      r0   = rdy_low;
      build_expected();
      send_words(95, pct);
      for (int c = 0; c < 400 && out_q.size() < base + 97; c++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      chk({name, "_out_count"}, 64'(out_q.size() - base), 64'd97);
      chk({name, "_rdy_low_cycles"}, 64'(rdy_low - r0), 64'd2);
      for (int w = 0; w < 97; w++) begin
         e = '0;
         for (int b = 0; b < 8; b++) e = {e[55:0], exp_b[8*w+b]};
         if (base + w < out_q.size()) begin
            chk($sformatf("%s_word%0d", name, w), out_q[base+w].d, e);
            chk($sformatf("%s_sof%0d", name, w), 64'(out_q[base+w].sof), 64'(w == 0));
            for (int b = 0; b < 8; b++) ob[8*w+b] = out_q[base+w].d[63-8*b -: 8];
         end
      end
      if (synd) begin
         for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
               s = 8'h00;
               for (int i = 0; i < 194; i++) s = gmul(s, 8'(1 << j)) ^ ob[194*k+i];
               chk($sformatf("%s_synd_cw%0d_s%0d", name, k, j), 64'(s), 64'd0);
            end
         end
      end
   endtask

   task automatic chk_reset_state(input string name);
      chk({name, "_vld"},  64'(enc_data_vld), 64'd0);
      chk({name, "_data"}, enc_data,          64'd0);
      chk({name, "_sof"},  64'(enc_sof),      64'd0);
      chk({name, "_rdy"},  64'(tx_data_rdy),  64'd1);
   endtask

   initial begin
      vec_t tbl [4];
`ifdef RS_ENC_BYPASS_EN
      logic [63:0] pat;
`endif
      tbl[0] = '{8'h00, 32'h00000000};
      tbl[1] = '{8'h01, 32'h0F367840};
      tbl[2] = '{8'h02, 32'h1E6CF080};
      tbl[3] = '{8'h03, 32'h115A88C0};

      repeat (3) @(negedge clk);
      chk_reset_state("reset");
      rstn = 1'b1;
      @(posedge clk); #1;

      // Single nonzero message byte at the last message position of codeword 0.
      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < 760; i++) msg_b[i] = 8'h00;
         msg_b[189] = tbl[t].v;
         run_sf($sformatf("tbl%0d", t), 0, 1'b1);
         chk($sformatf("tbl%0d_parity", t), 64'({ob[190], ob[191], ob[192], ob[193]}),
             64'(tbl[t].par));
      end

      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 760; i++) msg_b[i] = 8'($urandom);
         run_sf($sformatf("rand%0d", r), 0, 1'b1);
      end

      // Same message with bubbles must yield the same stream.
`ifndef RS_ENC_BYPASS_EN
      rsfec_ena = 1'b0;
`endif
      run_sf("bubble", 50, 1'b1);
      rsfec_ena = 1'b1;

      for (int i = 0; i < 760; i++) msg_b[i] = 8'($urandom);
      send_words(40, 0);
      rstn = 1'b0;
      @(negedge clk);
      chk_reset_state("midrst");
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 760; i++) msg_b[i] = 8'($urandom);
      run_sf("after_rst", 0, 1'b1);

`ifdef RS_ENC_BYPASS_EN
      rsfec_ena = 1'b0;
      for (int i = 0; i < 4; i++) begin
         pat = (i == 0) ? 64'h0123456789ABCDEF : {$urandom, $urandom};
         tx_data     = pat;
         tx_data_vld = 1'b1;
         chk($sformatf("byp_rdy_pre%0d", i), 64'(tx_data_rdy), 64'd1);
         @(posedge clk); #1;
         chk($sformatf("byp_data%0d", i), enc_data, pat);
         chk($sformatf("byp_vld%0d", i), 64'(enc_data_vld), 64'd1);
         chk($sformatf("byp_sof%0d", i), 64'(enc_sof), 64'd0);
         chk($sformatf("byp_rdy%0d", i), 64'(tx_data_rdy), 64'd1);
      end
      tx_data_vld = 1'b0;
      rsfec_ena   = 1'b1;
      @(posedge clk); #1;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
